// File: rtl/neuron_sched.sv
// Round-robin scheduler sharing one digital neuron among NREQ requesters (CK1 domain).
// Optional settle check (second Q sample, RES_ERR output) under `define NEURON_SCHED_SETTLE_CHECK_EN.
module neuron_sched #(
  parameter int NREQ        = 4,
  parameter int EVAL_CYCLES = 2,
  localparam int IDW        = $clog2(NREQ)
) (
  input  logic                 CK1,
  input  logic                 RST,
  input  logic [NREQ-1:0]      REQ,
  input  logic [64*NREQ-1:0]   REQ_D,
  output logic [NREQ-1:0]      GNT,
  output logic [7:0]           D0,
  output logic [7:0]           D1,
  output logic [7:0]           D2,
  output logic [7:0]           D3,
  output logic [7:0]           D4,
  output logic [7:0]           D5,
  output logic [7:0]           D6,
  output logic [7:0]           D7,
  input  logic [7:0]           Q,
  output logic                 RES_VALID,
  input  logic                 RES_READY,
  output logic [7:0]           RES_Q,
  output logic [IDW-1:0]       RES_ID,
  output logic                 BUSY,
`ifdef NEURON_SCHED_SETTLE_CHECK_EN
  output logic                 RES_ERR,
`endif
  output logic [1:0]           state_dbg_o
);

  // Result handshake: RES_VALID rises together with RES_Q/RES_ID and all three hold
  // until an edge where RES_VALID && RES_READY; the transfer completes on that edge.
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_EVAL = 2'd1, S_RESP = 2'd2} state_t;

  localparam int CNTW = $clog2(EVAL_CYCLES + 1);

  state_t           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   win_q, win_d;
  logic [IDW-1:0]   resid_q, resid_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic [63:0]      din_q, din_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic             vld_q, vld_d;
  logic             busy_q, busy_d;
  logic [7:0]       resq_q, resq_d;
  logic             found;
  logic [IDW-1:0]   pick;

`ifdef NEURON_SCHED_SETTLE_CHECK_EN
  logic [7:0]       early_q, early_d;
  logic             err_q, err_d;

  if (EVAL_CYCLES < 2) begin : g_bad_eval
    $error("neuron_sched: settle check needs EVAL_CYCLES >= 2");
  end
`endif

  function automatic logic [IDW-1:0] rr_idx(input logic [IDW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NREQ) s = s - NREQ;
    return IDW'(s);
  endfunction

  // First set request bit at or after ptr, wrapping.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && REQ[rr_idx(ptr_q, k)]) begin
        found = 1'b1;
        pick  = rr_idx(ptr_q, k);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    cnt_d   = cnt_q;
    din_d   = din_q;
    gnt_d   = '0;
    vld_d   = vld_q;
    resq_d  = resq_q;
    resid_d = resid_q;
`ifdef NEURON_SCHED_SETTLE_CHECK_EN
    early_d = early_q;
    err_d   = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (found) begin
          din_d       = REQ_D[int'(pick)*64 +: 64];
          gnt_d[pick] = 1'b1;
          win_d       = pick;
          cnt_d       = CNTW'(EVAL_CYCLES);
          state_d     = S_EVAL;
        end
      end
      S_EVAL: begin
        cnt_d = cnt_q - 1'b1;
`ifdef NEURON_SCHED_SETTLE_CHECK_EN
        if (cnt_q == CNTW'(2)) early_d = Q;
`endif
        if (cnt_q == CNTW'(1)) begin
          resq_d  = Q;
          resid_d = win_q;
          vld_d   = 1'b1;
          state_d = S_RESP;
`ifdef NEURON_SCHED_SETTLE_CHECK_EN
          err_d   = (early_q != Q);
`endif
        end
      end
      S_RESP: begin
        if (RES_READY) begin
          vld_d   = 1'b0;
          ptr_d   = (win_q == IDW'(NREQ - 1)) ? '0 : win_q + 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge CK1 or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      cnt_q   <= '0;
      din_q   <= '0;
      gnt_q   <= '0;
      vld_q   <= 1'b0;
      resq_q  <= '0;
      resid_q <= '0;
      busy_q  <= 1'b0;
`ifdef NEURON_SCHED_SETTLE_CHECK_EN
      early_q <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
      din_q   <= din_d;
      gnt_q   <= gnt_d;
      vld_q   <= vld_d;
      resq_q  <= resq_d;
      resid_q <= resid_d;
      busy_q  <= busy_d;
`ifdef NEURON_SCHED_SETTLE_CHECK_EN
      early_q <= early_d;
      err_q   <= err_d;
`endif
    end
  end

  assign GNT         = gnt_q;
  assign D0          = din_q[7:0];
  assign D1          = din_q[15:8];
  assign D2          = din_q[23:16];
  assign D3          = din_q[31:24];
  assign D4          = din_q[39:32];
  assign D5          = din_q[47:40];
  assign D6          = din_q[55:48];
  assign D7          = din_q[63:56];
  assign RES_VALID   = vld_q;
  assign RES_Q       = resq_q;
  assign RES_ID      = resid_q;
  assign BUSY        = busy_q;
  assign state_dbg_o = state_q;
`ifdef NEURON_SCHED_SETTLE_CHECK_EN
  assign RES_ERR     = err_q;
`endif

endmodule

// File: tb/tb_neuron_sched.sv
// Testbench for neuron_sched: transaction-level predictor feeding an expected-result
// queue, a result monitor popping on each handshake, directed and random phases.
module tb_neuron_sched;

  localparam int NREQ        = 4;
  localparam int EVAL_CYCLES = 2;
  localparam int IDW         = 2;

  logic                CK1 = 1'b0;
  logic                RST;
  logic [NREQ-1:0]     REQ;
  logic [64*NREQ-1:0]  REQ_D;
  logic [NREQ-1:0]     GNT;
  logic [7:0]          D0, D1, D2, D3, D4, D5, D6, D7;
  logic [7:0]          Q;
  logic                RES_VALID;
  logic                RES_READY;
  logic [7:0]          RES_Q;
  logic [IDW-1:0]      RES_ID;
  logic                BUSY;
  logic [1:0]          state_dbg;
`ifdef NEURON_SCHED_SETTLE_CHECK_EN
  logic                RES_ERR;
`endif

  logic [63:0]         dbus;
  logic [63:0]         d_dly = '0;
  int                  cyc = 0;
  int                  n_tests = 0;
  int                  n_fail = 0;
  logic [10:0]         exp_q[$];

  neuron_sched #(.NREQ(NREQ), .EVAL_CYCLES(EVAL_CYCLES)) dut (
    .CK1(CK1), .RST(RST), .REQ(REQ), .REQ_D(REQ_D), .GNT(GNT),
    .D0(D0), .D1(D1), .D2(D2), .D3(D3), .D4(D4), .D5(D5), .D6(D6), .D7(D7),
    .Q(Q), .RES_VALID(RES_VALID), .RES_READY(RES_READY), .RES_Q(RES_Q),
    .RES_ID(RES_ID), .BUSY(BUSY),
`ifdef NEURON_SCHED_SETTLE_CHECK_EN
    .RES_ERR(RES_ERR),
`endif
    .state_dbg_o(state_dbg)
  );

  // ---------------- clock / neuron model ----------------
  always #5 CK1 = ~CK1;
  always @(posedge CK1) cyc++;

  assign dbus = {D7, D6, D5, D4, D3, D2, D1, D0};

  // Neuron: byte sum xor 0x7E, output settles one CK1 edge after its inputs change.
  function automatic logic [7:0] nmodel(input logic [63:0] v);
    logic [7:0] s;
    s = 8'h00;
    for (int i = 0; i < 8; i++) s = s + v[8*i +: 8];
    return s ^ 8'h7E;
  endfunction

  always @(posedge CK1) d_dly <= dbus;
  assign Q = nmodel(d_dly);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int rr_model(input logic [NREQ-1:0] req, input int p);
    for (int k = 0; k < NREQ; k++)
      if (req[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  // ---------------- predictor: transaction-level reference ----------------
  logic             m_idle = 1'b1;
  logic             m_valid = 1'b0;
  int               m_ptr = 0;
  int               m_win = 0;
  int               m_left = 0;
  logic [63:0]      m_d = '0;
  logic [63:0]      m_d_old = '0;
  logic [NREQ-1:0]  prev_req = '0;
  logic [64*NREQ-1:0] prev_data = '0;
  logic             prev_ready = 1'b0;
  logic             prev_rst = 1'b1;

  always @(negedge CK1) begin
    logic [NREQ-1:0] exp_gnt;
    int w;
    exp_gnt = '0;
    if (RST) begin
      m_idle = 1'b1; m_valid = 1'b0; m_ptr = 0; m_left = 0;
      m_d = '0; m_d_old = '0;
      exp_q.delete();
      chk("rst_gnt", 64'(GNT), 64'(0));
      chk("rst_busy", 64'(BUSY), 64'(0));
      chk("rst_valid", 64'(RES_VALID), 64'(0));
      chk("rst_d", dbus, 64'(0));
      chk("rst_res_q", 64'(RES_Q), 64'(0));
      chk("rst_res_id", 64'(RES_ID), 64'(0));
`ifdef NEURON_SCHED_SETTLE_CHECK_EN
      chk("rst_res_err", 64'(RES_ERR), 64'(0));
`endif
      prev_rst = 1'b1;
    end else begin
      if (!prev_rst) begin
        if (m_idle) begin
          if (prev_req != '0) begin
            w = rr_model(prev_req, m_ptr);
            exp_gnt[w] = 1'b1;
            m_win   = w;
            m_d_old = m_d;
            m_d     = prev_data[64*w +: 64];
            m_idle  = 1'b0;
            m_left  = EVAL_CYCLES;
            exp_q.push_back({nmodel(m_d_old) != nmodel(m_d), 2'(w), nmodel(m_d)});
          end
        end else if (m_left > 0) begin
          m_left--;
          if (m_left == 0) m_valid = 1'b1;
        end else if (m_valid && prev_ready) begin
          m_valid = 1'b0;
          m_idle  = 1'b1;
          m_ptr   = (m_win + 1) % NREQ;
        end
      end
      chk("gnt", 64'(GNT), 64'(exp_gnt));
      chk("busy", 64'(BUSY), 64'(!m_idle));
      chk("res_valid", 64'(RES_VALID), 64'(m_valid));
      chk("d_bus", dbus, m_d);
      prev_rst = 1'b0;
    end
    prev_req   = REQ;
    prev_data  = REQ_D;
    prev_ready = RES_READY;
  end

  // ---------------- monitor: pops on every result handshake ----------------
  always @(negedge CK1) begin
    logic [10:0] e;
    if (!RST && RES_VALID && RES_READY) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 64'(1), 64'(0));
      end else begin
        e = exp_q.pop_front();
        chk("res_q", 64'(RES_Q), 64'(e[7:0]));
        chk("res_id", 64'(RES_ID), 64'(e[9:8]));
`ifdef NEURON_SCHED_SETTLE_CHECK_EN
        chk("res_err", 64'(RES_ERR), 64'(e[10]));
`endif
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge CK1);
    #1;
  endtask

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  task automatic wait_gnt(input int i, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      tick();
      if (GNT[i]) ok = 1'b1;
    end
  endtask

  task automatic wait_any_gnt(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      tick();
      if (GNT != '0) ok = 1'b1;
    end
  endtask

  task automatic wait_valid(output bit ok);
    ok = RES_VALID;
    for (int c = 0; c < 20 && !ok; c++) begin
      tick();
      if (RES_VALID) ok = 1'b1;
    end
  endtask

  task automatic drain(input string name);
    bit done;
    REQ = '0;
    RES_READY = 1'b1;
    done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      tick();
      if (!BUSY && !RES_VALID) done = 1'b1;
    end
    chk(name, 64'(done), 64'(1));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit ok, held, nog;
    logic [NREQ-1:0] gord[5];
    int gcyc[5];
    int ng;
    logic [7:0] q0;
    logic [IDW-1:0] id0;
    logic [63:0] d0;

    RST = 1'b1; REQ = '0; REQ_D = '0; RES_READY = 1'b0;
    repeat (3) @(posedge CK1);
    #1 RST = 1'b0;

    // single request with a known vector
    REQ_D[63:0] = 64'h0807060504030201;
    REQ = 4'b0001;
    RES_READY = 1'b1;
    wait_gnt(0, ok);
    chk("single_gnt", 64'(ok), 64'(1));
    chk("single_d0", 64'(D0), 64'h01);
    chk("single_d7", 64'(D7), 64'h08);
    REQ[0] = 1'b0;
    wait_valid(ok);
    chk("single_valid", 64'(ok), 64'(1));
    chk("single_res_q", 64'(RES_Q), 64'h5A);
    chk("single_res_id", 64'(RES_ID), 64'(0));
    tick(); tick();

    // reset in the middle of an evaluation
    REQ_D[191:128] = rand64();
    REQ[2] = 1'b1;
    wait_gnt(2, ok);
    REQ[2] = 1'b0;
    tick();
    RST = 1'b1;
    #1;
    chk("midrst_busy", 64'(BUSY), 64'(0));
    chk("midrst_d", dbus, 64'(0));
    chk("midrst_valid", 64'(RES_VALID), 64'(0));
    chk("midrst_gnt", 64'(GNT), 64'(0));
    tick();
    RST = 1'b0;
    nog = 1'b1;
    repeat (6) begin
      tick();
      if (RES_VALID) nog = 1'b0;
    end
    chk("midrst_no_result", 64'(nog), 64'(1));

    // fairness: all requesting, consumer always ready
    for (int i = 0; i < NREQ; i++) REQ_D[64*i +: 64] = rand64();
    REQ = 4'b1111;
    RES_READY = 1'b1;
    ng = 0;
    for (int c = 0; c < 40 && ng < 5; c++) begin
      tick();
      if (GNT != '0) begin
        gord[ng] = GNT;
        gcyc[ng] = cyc;
        ng++;
        for (int i = 0; i < NREQ; i++) if (GNT[i]) REQ_D[64*i +: 64] = rand64();
      end
    end
    REQ = '0;
    chk("fair_count", 64'(ng), 64'(5));
    for (int k = 0; k < 5; k++)
      chk($sformatf("fair_order%0d", k), 64'(gord[k]), 64'(4'b0001 << (k % 4)));
    for (int k = 1; k < 5; k++)
      chk($sformatf("fair_gap%0d", k), 64'(gcyc[k] - gcyc[k-1]), 64'(EVAL_CYCLES + 2));
    drain("fair_drain");

    // backpressure with requester 1 pending
    RES_READY = 1'b0;
    REQ_D[63:0] = rand64();
    REQ = 4'b0001;
    wait_gnt(0, ok);
    REQ[0] = 1'b0;
    wait_valid(ok);
    chk("bp_valid", 64'(ok), 64'(1));
    REQ_D[127:64] = rand64();
    REQ[1] = 1'b1;
    q0 = RES_Q; id0 = RES_ID; d0 = dbus;
    held = 1'b1; nog = 1'b1;
    repeat (5) begin
      tick();
      if (RES_VALID !== 1'b1 || RES_Q !== q0 || RES_ID !== id0 || dbus !== d0) held = 1'b0;
      if (GNT != '0) nog = 1'b0;
    end
    chk("bp_hold", 64'(held), 64'(1));
    chk("bp_no_gnt", 64'(nog), 64'(1));
    RES_READY = 1'b1;
    tick();
    chk("bp_ack_gnt", 64'(GNT), 64'(0));
    chk("bp_valid_drop", 64'(RES_VALID), 64'(0));
    tick();
    chk("bp_next_gnt", 64'(GNT), 64'(4'b0010));
    REQ[1] = 1'b0;
    drain("bp_drain");

    // withdrawal: requester 2 only asserts while busy
    RES_READY = 1'b0;
    REQ_D[63:0] = rand64();
    REQ = 4'b0001;
    wait_gnt(0, ok);
    REQ[0] = 1'b0;
    tick();
    REQ_D[191:128] = rand64();
    REQ[2] = 1'b1;
    nog = 1'b1;
    repeat (4) begin
      tick();
      if (GNT[2]) nog = 1'b0;
    end
    REQ[2] = 1'b0;
    RES_READY = 1'b1;
    repeat (4) begin
      tick();
      if (GNT[2]) nog = 1'b0;
    end
    chk("wd_no_gnt2", 64'(nog), 64'(1));
    REQ = 4'b1111;
    wait_any_gnt(ok);
    chk("wd_ptr", 64'(GNT), 64'(4'b0010));
    drain("wd_drain");

    // random traffic following the request protocol
    for (int c = 0; c < 600; c++) begin
      tick();
      RES_READY = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NREQ; i++) begin
        if (GNT[i]) begin
          if ($urandom_range(0, 1) == 1) REQ_D[64*i +: 64] = rand64();
          else REQ[i] = 1'b0;
        end else if (!REQ[i]) begin
          if ($urandom_range(0, 3) == 0) begin
            REQ_D[64*i +: 64] = rand64();
            REQ[i] = 1'b1;
          end
        end else if ($urandom_range(0, 15) == 0) begin
          REQ[i] = 1'b0;
        end
      end
    end
    drain("rand_drain");
    tick();
    chk("results_all_seen", 64'(exp_q.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
